// File: rtl/micro_core_mc.sv
// micro_core_mc: multi-cycle 4-op core (add/lw/sw/jmp) with signed 2-digit display.
// Define SATURATING_ADD_EN to make add saturate on signed overflow instead of wrapping.
module micro_core_mc #(
    parameter int DATA_W     = 8,
    parameter int DMEM_DEPTH = 32,
    parameter int PC_W       = 8
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [7:0]      Instruction,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [PC_W-1:0] ReadAddress,
    output logic [6:0]      Tens,
    output logic [6:0]      Ones,
    output logic            Sign,
    output logic            busy
);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_LW, OP_SW, OP_JMP} op_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [7:0]        ir_q;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [AW-1:0]     addr_q;
    logic [6:0]        tens_q, ones_q;
    logic              sign_q;

    op_t               op;
    logic [1:0]        rs, rt, rd;
    logic [DATA_W-1:0] sum_d, add_d;
    logic [AW-1:0]     addr_d;
    logic [PC_W-1:0]   jmp_d;
    logic [DATA_W:0]   mag_d;
    logic [6:0]        sat_d;
    logic [3:0]        tens_d, ones_d;

    assign op = op_t'(ir_q[7:6]);
    assign rs = ir_q[5:4];
    assign rt = ir_q[3:2];
    assign rd = ir_q[1:0];

    assign sum_d  = a_q + b_q;
    assign addr_d = a_q[AW-1:0] + {{(AW-2){ir_q[1]}}, ir_q[1:0]};
    assign jmp_d  = pc_q + {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

`ifdef SATURATING_ADD_EN
    logic ovf;
    assign ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                 (sum_d[DATA_W-1] != a_q[DATA_W-1]);
    always_comb begin
        add_d = sum_d;
        if (ovf)
            add_d = a_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    assign add_d = sum_d;
`endif

    // Extra bit so |-2^(DATA_W-1)| is representable before saturation
    assign mag_d  = res_q[DATA_W-1] ? ({1'b0, ~res_q} + 1'b1)
                                    : {1'b0, res_q};
    assign sat_d  = (mag_d > (DATA_W+1)'(99)) ? 7'd99 : mag_d[6:0];
    assign tens_d = 4'(sat_d / 7'd10);
    assign ones_d = 4'(sat_d % 7'd10);

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            addr_q  <= '0;
            tens_q  <= 7'b0000001;
            ones_q  <= 7'b0000001;
            sign_q  <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs_q[i] <= DATA_W'(i);
            for (int i = 0; i < DMEM_DEPTH; i++)
                dmem_q[i] <= DATA_W'(i - 15);
        end else begin
            case (state_q)
                FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= Instruction;
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    a_q <= regs_q[rs];
                    b_q <= regs_q[rt];
                    if (op == OP_JMP) begin
                        pc_q    <= jmp_d;
                        state_q <= FETCH;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (op == OP_ADD) begin
                        res_q   <= add_d;
                        state_q <= WB;
                    end else begin
                        addr_q  <= addr_d;
                        state_q <= MEM;
                    end
                end
                MEM: begin
                    if (op == OP_SW) begin
                        dmem_q[addr_q] <= b_q;
                        state_q        <= FETCH;
                    end else begin
                        res_q   <= dmem_q[addr_q];
                        state_q <= WB;
                    end
                end
                WB: begin
                    if (op == OP_ADD) regs_q[rd] <= res_q;
                    else              regs_q[rt] <= res_q;
                    tens_q  <= seg(tens_d);
                    ones_q  <= seg(ones_d);
                    sign_q  <= res_q[DATA_W-1];
                    state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign instr_ready = (state_q == FETCH) && !Reset;
    assign busy        = (state_q != FETCH);
    assign ReadAddress = pc_q;
    assign Tens        = tens_q;
    assign Ones        = ones_q;
    assign Sign        = sign_q;
endmodule

// File: tb/tb_micro_core_mc.sv
// Directed bench for micro_core_mc: latency, display, jmp, wrap and mid-sw reset.
module tb_micro_core_mc;
    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] Instruction;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] ReadAddress;
    logic [6:0] Tens, Ones;
    logic       Sign, busy;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S9 = 7'b0000100;

    micro_core_mc dut (
        .clk(clk), .Reset(Reset), .Instruction(Instruction),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ReadAddress(ReadAddress), .Tens(Tens), .Ones(Ones),
        .Sign(Sign), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input string tag, input logic s,
                        input logic [6:0] t, input logic [6:0] o);
        chk({tag, "_sign"}, 32'(Sign), 32'(s));
        chk({tag, "_tens"}, 32'(Tens), 32'(t));
        chk({tag, "_ones"}, 32'(Ones), 32'(o));
    endtask

    // Called at a negedge with the core in FETCH; returns at the
    // negedge where instr_ready is seen again.
    task automatic issue(input logic [7:0] ins, input int lat,
                         input string tag);
        int n;
        chk({tag, "_rdy"}, 32'(instr_ready), 32'd1);
        Instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        instr_valid = 1'b0;
        while (!instr_ready && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
    endtask

    initial begin
        Reset = 1'b1;
        instr_valid = 1'b0;
        Instruction = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(instr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(ReadAddress), 32'd0);
        disp("rst", 1'b0, S0, S0);
        Reset = 1'b0;
        #1;
        chk("rel_rdy", 32'(instr_ready), 32'd1);
        @(negedge clk);

        // add r2 = r0 + r1 = 1
        issue(8'b00_00_01_10, 4, "add1");
        disp("add1", 1'b0, S0, S1);
        chk("add1_pc", 32'(ReadAddress), 32'd1);

        // lw r0 <- dmem[r1-1] = -15
        issue(8'b01_01_00_11, 5, "lw1");
        disp("lw1", 1'b1, S1, S5);
        chk("lw1_pc", 32'(ReadAddress), 32'd2);

        // sw dmem[1] <- r0 (-15); display holds
        issue(8'b10_10_00_00, 4, "sw1");
        disp("sw1", 1'b1, S1, S5);

        // lw r3 <- dmem[1]
        issue(8'b01_10_11_00, 5, "lw2");
        disp("lw2", 1'b1, S1, S5);

        // add r0 = r3 + r2 = -14 proves r3 held -15
        issue(8'b00_11_10_00, 4, "add2");
        disp("add2", 1'b1, S1, S4);
        chk("pre_jmp_pc", 32'(ReadAddress), 32'd5);

        // jmp -2 at PC 5: 6 - 2 = 4
        issue(8'b11_111110, 2, "jmp");
        chk("jmp_pc", 32'(ReadAddress), 32'd4);
        disp("jmp", 1'b1, S1, S4);

        // r1 doubles: 2,4,8,16,32,64,-128
        for (int k = 1; k <= 7; k++) begin
            issue(8'b00_01_01_01, 4, "dbl");
            if (k == 4) disp("dbl16", 1'b0, S1, S6);
            if (k == 6) disp("dbl64", 1'b0, S6, S4);
        end
        disp("dbl_wrap", 1'b1, S9, S9);

        // sw dmem[1] <- r1 (-128), reset while in MEM
        Instruction = 8'b10_10_01_00;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mem_busy", 32'(busy), 32'd1);
        Reset = 1'b1;
        #1;
        chk("mrst_rdy", 32'(instr_ready), 32'd0);
        chk("mrst_pc", 32'(ReadAddress), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        disp("mrst", 1'b0, S0, S0);
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        chk("mrel_rdy", 32'(instr_ready), 32'd1);
        @(negedge clk);

        // lw r1 <- dmem[r0+1]: reinitialised -14, sw discarded
        issue(8'b01_00_01_01, 5, "lw3");
        disp("lw3", 1'b1, S1, S4);
        chk("lw3_pc", 32'(ReadAddress), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
